// File: rtl/cola_pkg.sv
// Shared constants and helpers for the result capture queue.
package cola_pkg;

  localparam logic MODO_SUMA  = 1'b1;
  localparam logic MODO_RESTA = 1'b0;

  localparam int unsigned DATO_LSB = 0;

  // Tag bits sit directly above a result word of width w.
  function automatic int unsigned flag_bit(input int unsigned w);
    return w;
  endfunction

  function automatic int unsigned modo_bit(input int unsigned w);
    return w + 1;
  endfunction

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Register array: one synchronous write port, one asynchronous read port.
module fifo_mem
  import cola_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned EW    = 7
) (
  input  logic                      clk,
  input  logic                      i_we,
  input  logic [clog2(DEPTH)-1:0]   i_waddr,
  input  logic [EW-1:0]             i_wdata,
  input  logic [clog2(DEPTH)-1:0]   i_raddr,
  output logic [EW-1:0]             o_rdata
);

  logic [EW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/cola_resultados.sv
// Captures adder/subtractor results into a FWFT FIFO; overflow results are dropped and counted.
module cola_resultados
  import cola_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned W      = 5,
  parameter int unsigned DROP_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic                    in_sel,
  input  logic [W-1:0]            in_sal,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [W-1:0]            out_dato,
  output logic                    out_modo,
  output logic                    out_flag,
  output logic [clog2(DEPTH):0]   count,
  output logic                    lleno,
  output logic [DROP_W-1:0]       drop_cnt
);

  localparam int unsigned PW = clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned EW = W + 2;
  localparam int unsigned FB = flag_bit(W);
  localparam int unsigned MB = modo_bit(W);

  logic [PW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [DROP_W-1:0] r_drop;

  logic          w_full, w_pop, w_push, w_drop;
  logic [EW-1:0] w_wr_entry, w_rd_entry;

  assign w_full = (r_count == CW'(DEPTH));
  assign w_pop  = (r_count != '0) && out_ready;
  // A pop on the same edge frees a slot, so a full queue may still accept.
  assign w_push = in_valid && (!w_full || w_pop);
  assign w_drop = in_valid && w_full && !w_pop;

  always_comb begin
    w_wr_entry              = '0;
    w_wr_entry[W-1:DATO_LSB] = in_sal;
    w_wr_entry[FB]          = in_sal[W-1];
    w_wr_entry[MB]          = in_sel;
  end

  fifo_mem #(
    .DEPTH (DEPTH),
    .EW    (EW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wr_entry),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_entry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_drop   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
      if (w_drop && (r_drop != '1)) r_drop <= r_drop + DROP_W'(1);
    end
  end

  // Head fields are masked while empty so stale storage never shows after reset.
  assign out_valid = (r_count != '0);
  assign out_dato  = out_valid ? w_rd_entry[W-1:DATO_LSB] : '0;
  assign out_flag  = out_valid ? w_rd_entry[FB] : 1'b0;
  assign out_modo  = out_valid ? w_rd_entry[MB] : 1'b0;
  assign count     = r_count;
  assign lleno     = w_full;
  assign drop_cnt  = r_drop;

endmodule

// File: doc/cola_resultados.md
Name: cola_resultados

Overview:
- Downstream capture stage for the 4-bit sumador/restador.
- Samples each 5-bit result when the producer strobes it, tags it with the operation mode and a decoded flag, and buffers it in a small FIFO.
- Consumers (display/serial stages) drain it with a valid/ready handshake.
- The producer has no backpressure, so results that arrive when the FIFO is full are dropped and counted.

Parameters:
- DEPTH, 4: FIFO entries; power of two, minimum 2.
- W, 5: result width (4-bit operands plus carry/borrow bit).
- DROP_W, 8: width of the saturating drop counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  result strobe from the adder/subtractor; one result per high cycle.
- in_sel  in  1  mode of the result: 1 = suma, 0 = resta.
- in_sal  in  W  result word: suma = ent1+ent2 (unsigned, 5 bits); resta = ent1-ent2 (5-bit two's complement).
- out_valid  out  1  head entry available.
- out_ready  in  1  consumer accepts the head entry.
- out_dato  out  W  head result word.
- out_modo  out  1  head mode bit.
- out_flag  out  1  suma: carry (in_sal[W-1]); resta: negative (in_sal[W-1]), meaning ent2 > ent1.
- count  out  clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- lleno  out  1  count == DEPTH.
- drop_cnt  out  DROP_W  number of results dropped because the FIFO was full; saturates at all-ones.

Behaviour:
- Reset (rst_n low, asynchronous assert, synchronous-to-clk deassert in effect):
  - out_valid=0, out_dato=0, out_modo=0, out_flag=0, count=0, lleno=0, drop_cnt=0.
  - Read and write pointers cleared.
  - FIFO storage contents need not be cleared.
- Entry format:
  - {modo, flag, dato}, where flag = in_sal[W-1] regardless of mode.
  - The flag is stored at push time, not recomputed at the output.
- Push:
  - Occurs on an edge where in_valid=1 and (count<DEPTH, or a pop occurs on the same edge).
- Pop:
  - Occurs on an edge where out_valid=1 and out_ready=1.
- Read mode: first-word-fall-through.
  - out_valid is the registered state (count != 0).
  - out_dato/out_modo/out_flag show the head entry combinationally from storage at the read pointer.
  - They are stable while out_valid=1 and no pop occurs.
- Latency: a result pushed into an empty FIFO at edge N is visible with out_valid=1 after edge N (one cycle).
- Simultaneous push and pop:
  - Count is unchanged; both pointers advance.
  - This is allowed when full: the slot freed by the pop takes the new result, and no drop occurs.
- Empty with in_valid=1 and out_ready=1 on the same edge: no pop (out_valid was 0); push only, count becomes 1.
- Full with in_valid=1 and no pop:
  - Result discarded; storage and pointers unchanged.
  - drop_cnt increments by 1 unless it is already all-ones.
- Pointers:
  - clog2(DEPTH) bits, wrap naturally modulo DEPTH.
  - count is kept as an explicit up/down counter: +1 on push only, -1 on pop only, unchanged on both or neither.
- Reset mid-operation: all contents are lost immediately on rst_n low, out_valid drops asynchronously, and no partial push completes.
- in_sel and in_sal are ignored when in_valid=0.
- out_ready is ignored when out_valid=0.

Decomposition:
- Shared package (cola_pkg) holds:
  - localparams MODO_SUMA=1'b1 and MODO_RESTA=1'b0;
  - the entry field positions (DATO_LSB=0, FLAG_BIT=W, MODO_BIT=W+1);
  - a clog2 function for pointer and count widths.
- One natural sub-module: fifo_mem, a DEPTH x (W+2) register array with a single synchronous write port and an asynchronous read port.
- Pointer, count and drop logic stay in cola_resultados.

Test Plan:
- Reset and idle:
  - Stimulus: hold rst_n=0 for 3 cycles with in_valid=1 and in_sal=5'h1F.
  - Required: out_valid=0, count=0, drop_cnt=0 throughout; after release with in_valid=0, nothing changes.
- Suma ordering:
  - Stimulus: push (sel=1, sal=15), (1, 16), (1, 17) on consecutive cycles with out_ready=0.
  - Required: count=3; then out_ready=1 pops dato=15/flag=0, dato=16/flag=1, dato=17/flag=1, all modo=1; count returns to 0.
- Resta flag:
  - Stimulus: push sel=0 with sal=5'b01111 (15-0) and then sal=5'b11111 (0-1).
  - Required: out_flag=0 then 1, out_modo=0 for both.
- Full and drop:
  - Stimulus: with out_ready=0, push 6 results (values 1..6).
  - Required: lleno=1 after the 4th push, drop_cnt=2; draining yields exactly 1,2,3,4.
- Simultaneous push and pop at full:
  - Stimulus: FIFO full holding 1..4; one edge with in_valid=1 (sal=9) and out_ready=1.
  - Required: count stays 4, drop_cnt unchanged; draining yields 2,3,4,9.
- Drop saturation and mid-run reset:
  - Stimulus: FIFO full, 300 further pushes, then pulse rst_n low for one cycle while out_valid=1.
  - Required: drop_cnt saturates at 255; after reset, out_valid=0, count=0, drop_cnt=0.
